// File: rtl/ddr_seq_pkg.sv
// Shared types and default timing for the DDR power-up / recovery sequencer.
// Holds the state encoding, the registered-output bundle and the decoder that
// maps a state onto that bundle.
package ddr_seq_pkg;

  // State encoding is part of the external debug interface (state port).
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_PLL_RST   = 4'd1,
    ST_PLL_WAIT  = 4'd2,
    ST_PHY_REL   = 4'd3,
    ST_CFG_RST   = 4'd4,
    ST_CFG_START = 4'd5,
    ST_CFG_WAIT  = 4'd6,
    ST_RUN       = 4'd7,
    ST_FAIL      = 4'd8
  } state_e;

  // Default timing, in clk_100 cycles.
  localparam int unsigned DEF_TIMER_W         = 24;
  localparam int unsigned DEF_PLL_RST_CYC     = 100;
  localparam int unsigned DEF_LOCK_STABLE_CYC = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT    = 1_000_000;
  localparam int unsigned DEF_RST_HOLD_CYC    = 200;
  localparam int unsigned DEF_CFG_RST_CYC     = 16;
  localparam int unsigned DEF_CFG_TIMEOUT     = 10_000_000;
  localparam int unsigned DEF_MAX_RETRIES     = 3;

  // Every sequencer output except state/retry_cnt, kept together so one
  // register stage covers all of them.
  typedef struct packed {
    logic ddr_pll_rstn;
    logic phy_rstn;
    logic ctrl_rstn;
    logic cfg_sel;
    logic cfg_start;
    logic cfg_reset;
    logic axi_aresetn;
    logic reg_aresetn;
    logic ready;
    logic error;
  } outs_t;

  // Everything held in reset; cfg_reset is active-high so it sits at 1.
  localparam outs_t OUTS_RESET = '{
    ddr_pll_rstn: 1'b0, phy_rstn: 1'b0, ctrl_rstn: 1'b0,
    cfg_sel: 1'b0, cfg_start: 1'b0, cfg_reset: 1'b1,
    axi_aresetn: 1'b0, reg_aresetn: 1'b0, ready: 1'b0, error: 1'b0
  };

  // Output pattern while sitting in state s. Later states keep everything
  // released by the earlier ones, so the ranges below nest.
  function automatic outs_t decode_outs(state_e s);
    outs_t o;
    o = OUTS_RESET;
    if (s inside {ST_PLL_WAIT, ST_PHY_REL, ST_CFG_RST, ST_CFG_START, ST_CFG_WAIT, ST_RUN}) begin
      o.ddr_pll_rstn = 1'b1;
    end
    if (s inside {ST_PHY_REL, ST_CFG_RST, ST_CFG_START, ST_CFG_WAIT, ST_RUN}) begin
      o.phy_rstn    = 1'b1;
      o.ctrl_rstn   = 1'b1;
      o.reg_aresetn = 1'b1;
    end
    if (s inside {ST_CFG_RST, ST_CFG_START, ST_CFG_WAIT, ST_RUN}) begin
      o.cfg_sel = 1'b1;
    end
    if (s inside {ST_CFG_START, ST_CFG_WAIT, ST_RUN}) begin
      o.cfg_reset = 1'b0;
    end
    if (s == ST_CFG_START) begin
      o.cfg_start = 1'b1;
    end
    if (s == ST_RUN) begin
      o.axi_aresetn = 1'b1;
      o.ready       = 1'b1;
    end
    if (s == ST_FAIL) begin
      o.error = 1'b1;
    end
    return o;
  endfunction

endpackage

// File: rtl/ddr_init_sequencer_sync2.sv
// Two-flop synchroniser for a single asynchronous level into clk_i.
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ddr_init_sequencer.sv
// LPDDR4 power-up and recovery sequencer. Walks PLL reset, lock wait, PHY and
// controller release, configuration handshake and finally AXI release, with a
// bounded number of retries on timeout or lock loss.
//
// Handshake note: start is a single-cycle request sampled on every edge; it is
// acted on in IDLE, RUN and FAIL and ignored in every other state. ddr_pll_lock
// and cfg_done are plain asynchronous levels with no handshake back.
module ddr_init_sequencer
  import ddr_seq_pkg::*;
#(
  parameter int unsigned TIMER_W         = DEF_TIMER_W,
  parameter int unsigned PLL_RST_CYC     = DEF_PLL_RST_CYC,
  parameter int unsigned LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
  parameter int unsigned LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
  parameter int unsigned RST_HOLD_CYC    = DEF_RST_HOLD_CYC,
  parameter int unsigned CFG_RST_CYC     = DEF_CFG_RST_CYC,
  parameter int unsigned CFG_TIMEOUT     = DEF_CFG_TIMEOUT,
  parameter int unsigned MAX_RETRIES     = DEF_MAX_RETRIES,
  parameter bit          AUTO_START      = 1'b1
) (
  input  logic       clk_100,
  input  logic       rst,
  input  logic       start,
  input  logic       ddr_pll_lock,
  input  logic       cfg_done,
  output logic       ddr_pll_rstn,
  output logic       phy_rstn,
  output logic       ctrl_rstn,
  output logic       cfg_sel,
  output logic       cfg_start,
  output logic       cfg_reset,
  output logic       axi_aresetn,
  output logic       reg_aresetn,
  output logic       ready,
  output logic       error,
  output logic [3:0] state,
  output logic [1:0] retry_cnt
);

  // The shared timer must be able to hold every load value.
  localparam longint unsigned TIMER_MAX = (64'd1 << TIMER_W) - 64'd1;

  if (64'(PLL_RST_CYC) > TIMER_MAX || 64'(LOCK_STABLE_CYC) > TIMER_MAX ||
      64'(LOCK_TIMEOUT) > TIMER_MAX || 64'(RST_HOLD_CYC) > TIMER_MAX ||
      64'(CFG_RST_CYC) > TIMER_MAX || 64'(CFG_TIMEOUT) > TIMER_MAX) begin : g_timer_w_check
    $error("ddr_init_sequencer: TIMER_W too narrow for timing parameters");
  end

  if (MAX_RETRIES < 1 || MAX_RETRIES > 3) begin : g_retry_check
    $error("ddr_init_sequencer: MAX_RETRIES must fit the 2-bit retry_cnt");
  end

  // Timed states load N-1 on entry and leave on the cycle after reaching 0.
  localparam logic [TIMER_W-1:0] ONE         = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] LD_PLL_RST  = TIMER_W'(PLL_RST_CYC - 1);
  localparam logic [TIMER_W-1:0] LD_LOCK_TO  = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] LD_HOLD     = TIMER_W'(RST_HOLD_CYC - 1);
  localparam logic [TIMER_W-1:0] LD_CFG_RST  = TIMER_W'(CFG_RST_CYC - 1);
  localparam logic [TIMER_W-1:0] LD_CFG_TO   = TIMER_W'(CFG_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_STABLE_CYC - 1);

  logic               lock_s;
  logic               done_s;
  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] stab_q, stab_d;
  logic [1:0]         retry_q, retry_d;
  logic [1:0]         retry_inc;
  logic               fail_evt;
  outs_t              outs_q;

  sync2 u_sync_lock (
    .clk_i (clk_100),
    .rst_i (rst),
    .d_i   (ddr_pll_lock),
    .q_o   (lock_s)
  );

  sync2 u_sync_done (
    .clk_i (clk_100),
    .rst_i (rst),
    .d_i   (cfg_done),
    .q_o   (done_s)
  );

  assign retry_inc = retry_q + 2'd1;

  // Next-state, timer, stability-count and retry decisions for the sequencer.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    stab_d   = stab_q;
    retry_d  = retry_q;
    fail_evt = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start || AUTO_START) begin
          state_d = ST_PLL_RST;
          timer_d = LD_PLL_RST;
          retry_d = 2'd0;
        end
      end

      ST_PLL_RST: begin
        if (timer_q == '0) begin
          state_d = ST_PLL_WAIT;
          timer_d = LD_LOCK_TO;
          stab_d  = '0;
        end else begin
          timer_d = timer_q - ONE;
        end
      end

      // Lock must be seen LOCK_STABLE_CYC times in a row; a low sample
      // restarts the count. Reaching stability wins over a same-cycle timeout.
      ST_PLL_WAIT: begin
        if (lock_s && stab_q == LOCK_LAST) begin
          state_d = ST_PHY_REL;
          timer_d = LD_HOLD;
        end else if (timer_q == '0) begin
          fail_evt = 1'b1;
        end else begin
          timer_d = timer_q - ONE;
          stab_d  = lock_s ? (stab_q + ONE) : '0;
        end
      end

      ST_PHY_REL: begin
        if (!lock_s) begin
          fail_evt = 1'b1;
        end else if (timer_q == '0) begin
          state_d = ST_CFG_RST;
          timer_d = LD_CFG_RST;
        end else begin
          timer_d = timer_q - ONE;
        end
      end

      ST_CFG_RST: begin
        if (!lock_s) begin
          fail_evt = 1'b1;
        end else if (timer_q == '0) begin
          state_d = ST_CFG_START;
          timer_d = '0;
        end else begin
          timer_d = timer_q - ONE;
        end
      end

      ST_CFG_START: begin
        if (!lock_s) begin
          fail_evt = 1'b1;
        end else begin
          state_d = ST_CFG_WAIT;
          timer_d = LD_CFG_TO;
        end
      end

      // Lock loss is checked before cfg_done so it wins a same-cycle tie.
      ST_CFG_WAIT: begin
        if (!lock_s) begin
          fail_evt = 1'b1;
        end else if (done_s) begin
          state_d = ST_RUN;
        end else if (timer_q == '0) begin
          fail_evt = 1'b1;
        end else begin
          timer_d = timer_q - ONE;
        end
      end

      // An explicit re-init request takes priority over a coincident lock loss.
      ST_RUN: begin
        if (start) begin
          state_d = ST_PLL_RST;
          timer_d = LD_PLL_RST;
          retry_d = 2'd0;
        end else if (!lock_s) begin
          fail_evt = 1'b1;
        end
      end

      ST_FAIL: begin
        if (start) begin
          state_d = ST_PLL_RST;
          timer_d = LD_PLL_RST;
          retry_d = 2'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fail_evt) begin
      retry_d = retry_inc;
      timer_d = LD_PLL_RST;
      state_d = (32'(retry_inc) >= MAX_RETRIES) ? ST_FAIL : ST_PLL_RST;
    end
  end

  // State, counters and outputs; outputs are decoded from the next state so
  // they change on the same edge as the state they belong to.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      stab_q  <= '0;
      retry_q <= 2'd0;
      outs_q  <= OUTS_RESET;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      stab_q  <= stab_d;
      retry_q <= retry_d;
      outs_q  <= decode_outs(state_d);
    end
  end

  assign ddr_pll_rstn = outs_q.ddr_pll_rstn;
  assign phy_rstn     = outs_q.phy_rstn;
  assign ctrl_rstn    = outs_q.ctrl_rstn;
  assign cfg_sel      = outs_q.cfg_sel;
  assign cfg_start    = outs_q.cfg_start;
  assign cfg_reset    = outs_q.cfg_reset;
  assign axi_aresetn  = outs_q.axi_aresetn;
  assign reg_aresetn  = outs_q.reg_aresetn;
  assign ready        = outs_q.ready;
  assign error        = outs_q.error;
  assign state        = state_q;
  assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_ddr_init_sequencer.sv
// Directed bench for ddr_init_sequencer with shortened timing.
module tb_ddr_init_sequencer;
  import ddr_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk_100 = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ddr_pll_lock = 1'b0;
  logic       cfg_done = 1'b0;
  logic       ddr_pll_rstn, phy_rstn, ctrl_rstn;
  logic       cfg_sel, cfg_start, cfg_reset;
  logic       axi_aresetn, reg_aresetn, ready, error;
  logic [3:0] state;
  logic [1:0] retry_cnt;

  always #5 clk_100 = ~clk_100;

  ddr_init_sequencer #(
    .TIMER_W         (24),
    .PLL_RST_CYC     (4),
    .LOCK_STABLE_CYC (3),
    .LOCK_TIMEOUT    (50),
    .RST_HOLD_CYC    (5),
    .CFG_RST_CYC     (2),
    .CFG_TIMEOUT     (40),
    .MAX_RETRIES     (3),
    .AUTO_START      (1'b1)
  ) dut (
    .clk_100      (clk_100),
    .rst          (rst),
    .start        (start),
    .ddr_pll_lock (ddr_pll_lock),
    .cfg_done     (cfg_done),
    .ddr_pll_rstn (ddr_pll_rstn),
    .phy_rstn     (phy_rstn),
    .ctrl_rstn    (ctrl_rstn),
    .cfg_sel      (cfg_sel),
    .cfg_start    (cfg_start),
    .cfg_reset    (cfg_reset),
    .axi_aresetn  (axi_aresetn),
    .reg_aresetn  (reg_aresetn),
    .ready        (ready),
    .error        (error),
    .state        (state),
    .retry_cnt    (retry_cnt)
  );

  // ---------------- scoreboard state ----------------
  int         n_pass = 0;
  int         n_total = 0;
  int         cstart_cnt = 0;
  logic [1:0] exp_q[$];
  bit         lock_manual = 1'b0;
  bit         cfg_never = 1'b0;

  // Expected output bundle per state:
  // {pll_rstn, phy_rstn, ctrl_rstn, cfg_sel, cfg_start, cfg_reset, axi_aresetn, reg_aresetn, ready, error}
  typedef struct {
    logic [3:0] st;
    logic [9:0] outs;
    int         dur;   // expected dwell in cycles, 0 = not timed here
  } vec_t;
  vec_t vecs[9];

  function automatic logic [9:0] outs_vec();
    return {ddr_pll_rstn, phy_rstn, ctrl_rstn, cfg_sel, cfg_start, cfg_reset,
            axi_aresetn, reg_aresetn, ready, error};
  endfunction

  // ---------------- driver / check tasks ----------------
  task automatic step();
    @(posedge clk_100);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic wait_state(input logic [3:0] s, input string name);
    int n;
    n = 0;
    while (state !== s && n < 500) begin
      step();
      n++;
    end
    chk({"reach_", name}, 32'(state), 32'(s));
  endtask

  task automatic dwell(output int n);
    logic [3:0] s0;
    s0 = state;
    n = 0;
    while (state === s0 && n < 1000) begin
      step();
      n++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Lock model: in auto mode lock rises 10 cycles after ddr_pll_rstn rises
  // and falls while the PLL is held in reset. In manual mode the test drives it.
  initial begin
    int lcnt;
    lcnt = 0;
    forever begin
      @(posedge clk_100);
      #2;
      if (!lock_manual) begin
        if (!ddr_pll_rstn) begin
          ddr_pll_lock = 1'b0;
          lcnt = 0;
        end else if (lcnt < 10) lcnt++;
        else ddr_pll_lock = 1'b1;
      end
    end
  end

  // Configuration model: cfg_done rises 20 cycles after cfg_reset releases
  // (which coincides with cfg_start) unless cfg_never is set.
  initial begin
    int ccnt;
    ccnt = 0;
    forever begin
      @(posedge clk_100);
      #2;
      if (cfg_never || cfg_reset) begin
        cfg_done = 1'b0;
        ccnt = 0;
      end else if (ccnt < 20) ccnt++;
      else cfg_done = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk_100);
      if (cfg_start === 1'b1) cstart_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    logic [1:0] r;

    vecs[0] = '{st: ST_IDLE,      outs: 10'b000_0_0_1_0_0_0_0, dur: 1};
    vecs[1] = '{st: ST_PLL_RST,   outs: 10'b000_0_0_1_0_0_0_0, dur: 4};
    vecs[2] = '{st: ST_PLL_WAIT,  outs: 10'b100_0_0_1_0_0_0_0, dur: 0};
    vecs[3] = '{st: ST_PHY_REL,   outs: 10'b111_0_0_1_0_1_0_0, dur: 5};
    vecs[4] = '{st: ST_CFG_RST,   outs: 10'b111_1_0_1_0_1_0_0, dur: 2};
    vecs[5] = '{st: ST_CFG_START, outs: 10'b111_1_1_0_0_1_0_0, dur: 1};
    vecs[6] = '{st: ST_CFG_WAIT,  outs: 10'b111_1_0_0_0_1_0_0, dur: 0};
    vecs[7] = '{st: ST_RUN,       outs: 10'b111_1_0_0_1_1_1_0, dur: 0};
    vecs[8] = '{st: ST_FAIL,      outs: 10'b000_0_0_1_0_0_0_1, dur: 0};

    // Reset values while rst is held.
    repeat (3) step();
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    chk("rst_outs", 32'(outs_vec()), 32'(vecs[0].outs));
    chk("rst_retry", 32'(retry_cnt), 32'd0);

    // 1. Nominal bring-up, table-driven over the state sequence.
    cstart_cnt = 0;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) wait_state(vecs[i].st, $sformatf("nom_s%0d", i));
      chk($sformatf("nom_outs_s%0d", i), 32'(outs_vec()), 32'(vecs[i].outs));
      if (vecs[i].dur > 0) begin
        dwell(n);
        chk($sformatf("nom_dwell_s%0d", i), n, vecs[i].dur);
      end
    end
    chk("nom_cfg_start_cycles", cstart_cnt, 1);
    chk("nom_retry", 32'(retry_cnt), 32'd0);

    // 2. Lock glitch: high 2, low 1, then high; stability count restarts.
    rst = 1'b1;
    lock_manual = 1'b1;
    ddr_pll_lock = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    wait_state(ST_PLL_WAIT, "glitch_pll_wait");
    ddr_pll_lock = 1'b1;
    step();
    step();
    ddr_pll_lock = 1'b0;
    step();
    ddr_pll_lock = 1'b1;
    dwell(n);
    chk("glitch_pll_wait_cycles", n + 3, 8);
    chk("glitch_next_state", 32'(state), 32'(ST_PHY_REL));
    wait_state(ST_RUN, "glitch_run");
    chk("glitch_retry", 32'(retry_cnt), 32'd0);

    // 4. Lock drops in RUN: 2 sync cycles plus 1 state cycle.
    ddr_pll_lock = 1'b0;
    step();
    step();
    chk("lockloss_ready_held", 32'(ready), 32'd1);
    step();
    chk("lockloss_ready", 32'(ready), 32'd0);
    chk("lockloss_axi", 32'(axi_aresetn), 32'd0);
    chk("lockloss_state", 32'(state), 32'(ST_PLL_RST));
    chk("lockloss_retry", 32'(retry_cnt), 32'd1);
    lock_manual = 1'b0;

    // 6a. start in CFG_RST is ignored.
    wait_state(ST_CFG_RST, "ign_cfg_rst");
    pulse_start();
    chk("ign_still_cfg_rst", 32'(state), 32'(ST_CFG_RST));
    step();
    chk("ign_cfg_start", 32'(state), 32'(ST_CFG_START));
    chk("ign_retry", 32'(retry_cnt), 32'd1);
    wait_state(ST_RUN, "rerun_run");
    chk("rerun_ready", 32'(ready), 32'd1);
    chk("rerun_retry_kept", 32'(retry_cnt), 32'd1);

    // 6b. start in RUN forces re-init.
    pulse_start();
    chk("reinit_state", 32'(state), 32'(ST_PLL_RST));
    chk("reinit_ready", 32'(ready), 32'd0);
    chk("reinit_retry", 32'(retry_cnt), 32'd0);

    // 3. cfg_done never arrives: three timeouts, then FAIL.
    cfg_never = 1'b1;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    for (int k = 0; k < 3; k++) begin
      wait_state(ST_CFG_WAIT, $sformatf("to_cfg_wait%0d", k));
      dwell(n);
      chk($sformatf("to_dwell%0d", k), n, 40);
      r = exp_q.pop_front();
      chk($sformatf("to_retry%0d", k), 32'(retry_cnt), 32'(r));
      chk($sformatf("to_state%0d", k), 32'(state), (r == 2'd3) ? 32'(ST_FAIL) : 32'(ST_PLL_RST));
    end
    chk("fail_outs", 32'(outs_vec()), 32'(vecs[8].outs));
    repeat (5) step();
    chk("fail_sticky", 32'(state), 32'(ST_FAIL));
    chk("fail_error", 32'(error), 32'd1);
    pulse_start();
    chk("fail_start_state", 32'(state), 32'(ST_PLL_RST));
    chk("fail_start_error", 32'(error), 32'd0);
    chk("fail_start_retry", 32'(retry_cnt), 32'd0);
    cfg_never = 1'b0;

    // 5. rst in CFG_WAIT.
    wait_state(ST_CFG_WAIT, "rst_cfg_wait");
    rst = 1'b1;
    step();
    chk("midrst_outs", 32'(outs_vec()), 32'(vecs[0].outs));
    chk("midrst_state", 32'(state), 32'(ST_IDLE));
    chk("midrst_retry", 32'(retry_cnt), 32'd0);
    rst = 1'b0;
    step();
    chk("midrst_autostart", 32'(state), 32'(ST_PLL_RST));
    wait_state(ST_RUN, "midrst_run");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
